ps2_tx: RTL and testbench

//   Host-to-device PS/2 transmitter, the other direction of ps2_rx on the same open-drain clk/data pair.

---
 rtl/ps2_tx_pkg.sv | 22 ++
 rtl/ps2_sync.sv | 39 +++
 rtl/ps2_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 types: byte type, host-to-device transmitter state encoding and parity helper.
package ps2_tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RELEASE   = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // Falls before the stop bit: d0..d7 plus parity.
    localparam logic [3:0] PAYLOAD_FALLS = 4'd9;

    function automatic logic odd_parity(input byte_t b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge strobe on clock.
module ps2_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2_clk_async_i,
    input  logic ps2_data_async_i,
    output logic ps2_clk_o,
    output logic ps2_data_o,
    output logic ps2_clk_fall_o
);

    // Bit 0 carries the clock pad, bit 1 the data pad; both idle high on an open-drain bus.
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        meta_d     = {ps2_data_async_i, ps2_clk_async_i};
        sync_d     = meta_q;
        clk_prev_d = sync_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign ps2_clk_o      = sync_q[0];
    assign ps2_data_o     = sync_q[1];
    assign ps2_clk_fall_o = clk_prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shifts one byte on device clock falls, checks the ack.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  ps2_clk_async_i,
    input  logic  ps2_data_async_i,
    input  byte_t data_i,
    input  logic  valid_i,
    output logic  ready_o,
    output logic  ps2_clk_oe_o,
    output logic  ps2_data_oe_o,
    output logic  done_o,
    output logic  error_o
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic ps2_clk_s;
    logic ps2_data_s;
    logic ps2_fall;

    ps2_sync u_sync (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .ps2_clk_async_i  (ps2_clk_async_i),
        .ps2_data_async_i (ps2_data_async_i),
        .ps2_clk_o        (ps2_clk_s),
        .ps2_data_o       (ps2_data_s),
        .ps2_clk_fall_o   (ps2_fall)
    );

    ps2_tx_state_t    state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             ack_err_q, ack_err_d;

    logic accept;
    logic timing_frame;

    assign ready_o = (state_q == IDLE);
    // The done cycle is already IDLE, but a request there is held off by one cycle.
    assign accept  = valid_i && ready_o && !done_q;
    assign timing_frame = (state_q == RELEASE) || (state_q == SHIFT) || (state_q == ACK);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        ack_err_d = ack_err_q;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (accept) begin
                    shift_d   = {odd_parity(data_i), data_i};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    to_cnt_d  = '0;
                    ack_err_d = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + INH_W'(1);
                if (inh_cnt_q == INH_START) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    state_d  = RELEASE;
                end
            end

            RELEASE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                to_cnt_d  = to_cnt_q + TO_W'(1);
                state_d   = SHIFT;
            end

            SHIFT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ps2_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == PAYLOAD_FALLS) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end
            end

            ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ps2_fall) begin
                    if (ps2_data_s) begin
                        error_d   = 1'b1;
                        ack_err_d = 1'b1;
                    end
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (ps2_clk_s && ps2_data_s) begin
                    done_d  = ~ack_err_q;
                    state_d = IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Device stopped clocking: let go of both lines and report once.
        if (timing_frame && (to_cnt_q == TO_LAST)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign done_o        = done_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on the open-drain clock/data pair.
module tb_ps2_tx;
    import ps2_tx_pkg::*;

    localparam int INH  = 50;
    localparam int TO   = 20000;
    localparam int HALF = 100;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    byte_t data_in = 8'h00;
    logic  valid = 1'b0;
    logic  ready, clk_oe, data_oe, done, error;
    logic  dev_clk_low = 1'b0;
    logic  dev_data_low = 1'b0;
    logic  ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    always #10 clk = ~clk;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .ps2_clk_async_i  (ps2_clk_line),
        .ps2_data_async_i (ps2_data_line),
        .data_i           (data_in),
        .valid_i          (valid),
        .ready_o          (ready),
        .ps2_clk_oe_o     (clk_oe),
        .ps2_data_oe_o    (data_oe),
        .done_o           (done),
        .error_o          (error)
    );

    int done_cnt = 0, err_cnt = 0, both_cnt = 0, clk_oe_cnt = 0, data_oe_cnt = 0, rdy_lo_cnt = 0;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        if (clk_oe === 1'b1) clk_oe_cnt++;
        if (data_oe === 1'b1) data_oe_cnt++;
        if (ready !== 1'b1) rdy_lo_cnt++;
    end

    int checks = 0;
    int failures = 0;
    int rdy_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_release(input string name);
        int n;
        n = 0;
        while (clk_oe !== 1'b0 && n < 1000) begin
            tick;
            n++;
        end
        chk(name, (n < 1000), 1);
    endtask

    // Device side of one host-to-device frame: sample start, then 10 clocked bits, then ack.
    task automatic device_frame(input bit do_ack, output logic [10:0] bits);
        bits    = '0;
        rdy_bad = 0;
        wait_release("release_seen");
        repeat (HALF) tick;
        bits[0] = ps2_data_line;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) tick;
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_line;
            if (ready !== 1'b0) rdy_bad++;
            if (i == 10 && do_ack) begin
                repeat (HALF / 2) tick;
                dev_data_low = 1'b1;
                repeat (HALF / 2) tick;
            end else begin
                repeat (HALF) tick;
            end
        end
        dev_clk_low = 1'b1;
        repeat (HALF) tick;
        dev_clk_low = 1'b0;
        repeat (HALF) tick;
        dev_data_low = 1'b0;
    endtask

    task automatic run_txn(input byte_t d, input bit ack, input bit par,
                           input int exp_done, input int exp_err, input int exp_lat);
        int d0, e0, b0, c0, lat, n;
        logic [10:0] bits, exp_bits;
        d0 = done_cnt; e0 = err_cnt; b0 = both_cnt; c0 = clk_oe_cnt;
        chk("ready_before", ready, 1);
        data_in = d;
        valid   = 1'b1;
        lat     = 0;
        while (ready === 1'b1 && lat < 4) begin
            tick;
            lat++;
        end
        chk("accept_latency", lat, exp_lat);
        // Busy: a new request with different data must be ignored.
        data_in = ~d;
        repeat (10) tick;
        valid = 1'b0;
        device_frame(ack, bits);
        exp_bits = {1'b1, par, d, 1'b0};
        chk("frame_bits", bits, exp_bits);
        n = 0;
        while (!(ready === 1'b1 && (done_cnt + err_cnt) > (d0 + e0)) && n < 500) begin
            tick;
            n++;
        end
        chk("end_seen", (n < 500), 1);
        chk("done_pulses", done_cnt - d0, exp_done);
        chk("error_pulses", err_cnt - e0, exp_err);
        chk("done_and_error", both_cnt - b0, 0);
        chk("clk_oe_cycles", clk_oe_cnt - c0, INH);
        chk("ready_in_frame", rdy_bad, 0);
        $display("TXN data=%02h ack=%0d bits=%b done=%0d err=%0d oe_cycles=%0d", d, ack, bits,
                 done_cnt - d0, err_cnt - e0, clk_oe_cnt - c0);
    endtask

    typedef struct {
        byte_t d;
        bit    ack;
        bit    par;
        int    exp_done;
        int    exp_err;
        int    exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int d0, e0, c0, dc0, r0, n;
        logic [3:0]  exp_oe;
        logic [10:0] rx_frame;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 2};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0, 2};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, 0, 1, 2};

        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("reset_ready", ready, 1);
        chk("reset_clk_oe", clk_oe, 0);
        chk("reset_data_oe", data_oe, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);

        foreach (vecs[i])
            run_txn(vecs[i].d, vecs[i].ack, vecs[i].par, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_lat);

        // Device never clocks: error exactly TO cycles after clock release.
        d0 = done_cnt; e0 = err_cnt;
        data_in = 8'hFF; valid = 1'b1;
        tick;
        valid = 1'b0;
        wait_release("timeout_release");
        n = 0;
        while (error !== 1'b1 && n < 25000) begin
            tick;
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_clk_oe", clk_oe, 0);
        chk("timeout_data_oe", data_oe, 0);
        chk("timeout_ready", ready, 1);
        repeat (5) tick;
        chk("timeout_errors", err_cnt - e0, 1);
        chk("timeout_dones", done_cnt - d0, 0);
        $display("TXN data=ff no-clock timeout_cycles=%0d", n);

        // Abort 8'hAA with reset after the 4th fall.
        d0 = done_cnt; e0 = err_cnt;
        exp_oe = 4'b0101;
        data_in = 8'hAA; valid = 1'b1;
        tick;
        valid = 1'b0;
        wait_release("abort_release");
        repeat (HALF) tick;
        for (int i = 1; i <= 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) tick;
            chk("abort_data_oe", data_oe, exp_oe[i-1]);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                repeat (HALF) tick;
            end
        end
        chk("abort_busy", ready, 0);
        reset = 1'b1;
        tick;
        chk("abort_clk_oe", clk_oe, 0);
        chk("abort_data_oe_after", data_oe, 0);
        chk("abort_ready", ready, 1);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (HALF) tick;
        chk("abort_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        $display("TXN data=aa aborted by reset after 4th fall");

        run_txn(8'h55, 1'b1, 1'b1, 1, 0, 1);

        // Device-originated frame while idle must not disturb the transmitter.
        d0 = done_cnt; e0 = err_cnt; c0 = clk_oe_cnt; dc0 = data_oe_cnt; r0 = rdy_lo_cnt;
        rx_frame = 11'b1_0_01110110_0;
        for (int i = 0; i < 11; i++) begin
            dev_data_low = ~rx_frame[i];
            repeat (HALF / 2) tick;
            dev_clk_low = 1'b1;
            repeat (HALF) tick;
            dev_clk_low = 1'b0;
            repeat (HALF / 2) tick;
        end
        dev_data_low = 1'b0;
        repeat (20) tick;
        chk("rx_clk_oe", clk_oe_cnt - c0, 0);
        chk("rx_data_oe", data_oe_cnt - dc0, 0);
        chk("rx_done", done_cnt - d0, 0);
        chk("rx_error", err_cnt - e0, 0);
        chk("rx_ready", rdy_lo_cnt - r0, 0);
        $display("TXN device frame 76 while idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
